// File: rtl/drive_sequencer_if.sv
// Signal bundle between the tracker/sonar front-end and the drive sequencer.
// The master drives the sensor inputs; the slave (the sequencer) drives the wheel pins.
interface drive_sequencer_if;
    logic       start;
    logic [2:0] track_state;
    logic       obstacle;
    logic [1:0] left;
    logic [1:0] right;
    logic [2:0] mode;
    logic [2:0] fsm_state;

    modport master (
        output start, track_state, obstacle,
        input  left, right, mode, fsm_state
    );

    modport slave (
        input  start, track_state, obstacle,
        output left, right, mode, fsm_state
    );
endinterface

// File: rtl/drive_sequencer.sv
// Drive controller for the line-following car: sequences idle/follow/obstacle/search/halt
// and inserts coast dead-time on every wheel direction reversal.
module drive_sequencer #(
    parameter int CNT_W          = 28,
    parameter int CLEAR_CYCLES   = 5_000_000,
    parameter int LOST_CYCLES    = 2_000_000,
    parameter int SEARCH_TIMEOUT = 200_000_000,
    parameter int DEADTIME       = 100_000
) (
    input  logic             clk,
    input  logic             rst,
    drive_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FOLLOW = 3'd1,
        S_OBST   = 3'd2,
        S_SEARCH = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    typedef enum logic {
        TURN_RIGHT = 1'b0,
        TURN_LEFT  = 1'b1
    } turn_t;

    localparam logic [1:0] FWD   = 2'b10;
    localparam logic [1:0] BWD   = 2'b01;
    localparam logic [1:0] COAST = 2'b00;

    localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOST_LAST   = CNT_W'(LOST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SEARCH_LAST = CNT_W'(SEARCH_TIMEOUT - 1);

    localparam int              DT_W    = (DEADTIME > 2) ? $clog2(DEADTIME) : 1;
    localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME - 1);

    state_t            state_q, state_d;
    turn_t             turn_q, turn_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [1:0]        hold_l_q, hold_r_q;
    logic [1:0]        cmd_l, cmd_r;
    logic [2:0]        mode_q, mode_d;
    logic [1:0]        left_q, right_q;
    logic [DT_W-1:0]   dt_l_q, dt_r_q;
    logic              track_valid;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic is_reversal(input logic [1:0] cur, input logic [1:0] cmd);
        return ((cur == FWD) && (cmd == BWD)) || ((cur == BWD) && (cmd == FWD));
    endfunction

    assign track_valid = (bus.track_state <= 3'd4);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        timer_d = timer_q;
        turn_d  = turn_q;
        cmd_l   = COAST;
        cmd_r   = COAST;
        mode_d  = 3'd0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    state_d = S_FOLLOW;
                    timer_d = '0;
                end
            end

            S_FOLLOW: begin
                if (bus.obstacle) begin
                    state_d = S_OBST;
                    timer_d = '0;
                end else if (track_valid) begin
                    timer_d = '0;
                    mode_d  = bus.track_state;
                    case (bus.track_state)
                        3'd1:    begin cmd_l = FWD; cmd_r = BWD; turn_d = TURN_RIGHT; end
                        3'd2:    begin cmd_l = BWD; cmd_r = FWD; turn_d = TURN_LEFT;  end
                        3'd3:    begin cmd_l = FWD; cmd_r = FWD; turn_d = TURN_RIGHT; end
                        3'd4:    begin cmd_l = FWD; cmd_r = FWD; turn_d = TURN_LEFT;  end
                        default: begin cmd_l = FWD; cmd_r = FWD; end
                    endcase
                end else begin
                    // Line momentarily lost: keep driving the last command while counting.
                    cmd_l  = hold_l_q;
                    cmd_r  = hold_r_q;
                    mode_d = mode_q;
                    if (timer_q >= LOST_LAST) begin
                        state_d = S_SEARCH;
                        timer_d = '0;
                    end else begin
                        timer_d = sat_inc(timer_q);
                    end
                end
            end

            S_SEARCH: begin
                if (bus.obstacle) begin
                    state_d = S_OBST;
                    timer_d = '0;
                end else begin
                    cmd_l = (turn_q == TURN_RIGHT) ? FWD : BWD;
                    cmd_r = (turn_q == TURN_RIGHT) ? BWD : FWD;
                    if (track_valid) begin
                        state_d = S_FOLLOW;
                        timer_d = '0;
                    end else if (timer_q >= SEARCH_LAST) begin
                        state_d = S_HALT;
                        timer_d = '0;
                    end else begin
                        timer_d = sat_inc(timer_q);
                    end
                end
            end

            S_OBST: begin
                // Timer counts consecutive obstacle-free cycles only.
                if (bus.obstacle) begin
                    timer_d = '0;
                end else if (timer_q >= CLEAR_LAST) begin
                    state_d = S_FOLLOW;
                    timer_d = '0;
                end else begin
                    timer_d = sat_inc(timer_q);
                end
            end

            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            turn_q   <= TURN_RIGHT;
            hold_l_q <= COAST;
            hold_r_q <= COAST;
            mode_q   <= 3'd0;
            left_q   <= COAST;
            right_q  <= COAST;
            dt_l_q   <= '0;
            dt_r_q   <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            turn_q   <= turn_d;
            hold_l_q <= cmd_l;
            hold_r_q <= cmd_r;
            mode_q   <= mode_d;

            // A started dead-time always completes; the wheel then takes whatever is commanded.
            if (dt_l_q != '0) begin
                dt_l_q <= dt_l_q - 1'b1;
            end else if (is_reversal(left_q, cmd_l)) begin
                left_q <= COAST;
                dt_l_q <= DT_LOAD;
            end else begin
                left_q <= cmd_l;
            end

            if (dt_r_q != '0) begin
                dt_r_q <= dt_r_q - 1'b1;
            end else if (is_reversal(right_q, cmd_r)) begin
                right_q <= COAST;
                dt_r_q  <= DT_LOAD;
            end else begin
                right_q <= cmd_r;
            end
        end
    end

    assign bus.left      = left_q;
    assign bus.right     = right_q;
    assign bus.mode      = mode_q;
    assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_drive_sequencer.sv
// Bench for drive_sequencer: directed scenarios plus a random soak, each cycle compared
// against a behavioural model of the drive rules.
module tb_drive_sequencer;
    localparam int CLEAR   = 4;
    localparam int LOST    = 3;
    localparam int TIMEOUT = 10;
    localparam int DEAD    = 2;

    localparam int M_IDLE   = 0;
    localparam int M_FOLLOW = 1;
    localparam int M_OBST   = 2;
    localparam int M_SEARCH = 3;
    localparam int M_HALT   = 4;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;

    drive_sequencer_if bus ();

    drive_sequencer #(
        .CNT_W         (28),
        .CLEAR_CYCLES  (CLEAR),
        .LOST_CYCLES   (LOST),
        .SEARCH_TIMEOUT(TIMEOUT),
        .DEADTIME      (DEAD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int         m_state;
    int         m_timer;
    logic       m_turn_left;
    logic [1:0] m_hold_l, m_hold_r;
    logic [2:0] m_mode;
    logic [1:0] m_left, m_right;
    int         m_l_until, m_r_until;
    int         m_cyc;
    logic [1:0] tbl_l [0:4];
    logic [1:0] tbl_r [0:4];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state     = M_IDLE;
        m_timer     = 0;
        m_turn_left = 1'b0;
        m_hold_l    = 2'b00;
        m_hold_r    = 2'b00;
        m_mode      = 3'd0;
        m_left      = 2'b00;
        m_right     = 2'b00;
        m_l_until   = 0;
        m_r_until   = 0;
        m_cyc       = 0;
    endtask

    // A wheel coasts until its dead-time window closes; opposite nonzero directions open a window.
    task automatic drive_wheel(inout logic [1:0] out, inout int coast_until, input logic [1:0] cmd);
        if (m_cyc < coast_until) begin
            out = 2'b00;
        end else if (out != 2'b00 && cmd != 2'b00 && out != cmd) begin
            out         = 2'b00;
            coast_until = m_cyc + DEAD;
        end else begin
            out = cmd;
        end
    endtask

    task automatic model_step(input logic st, input logic [2:0] tr, input logic ob);
        logic [1:0] cl, cr;
        logic [2:0] md;
        cl = 2'b00;
        cr = 2'b00;
        md = 3'd0;
        if (ob && (m_state == M_FOLLOW || m_state == M_SEARCH)) begin
            m_state = M_OBST;
            m_timer = 0;
        end else begin
            case (m_state)
                M_IDLE, M_HALT: begin
                    if (st) begin
                        m_state = M_FOLLOW;
                        m_timer = 0;
                    end
                end
                M_FOLLOW: begin
                    if (tr <= 3'd4) begin
                        cl      = tbl_l[int'(tr)];
                        cr      = tbl_r[int'(tr)];
                        md      = tr;
                        m_timer = 0;
                        if (tr == 3'd1 || tr == 3'd3) m_turn_left = 1'b0;
                        if (tr == 3'd2 || tr == 3'd4) m_turn_left = 1'b1;
                    end else begin
                        cl = m_hold_l;
                        cr = m_hold_r;
                        md = m_mode;
                        m_timer++;
                        if (m_timer >= LOST) begin
                            m_state = M_SEARCH;
                            m_timer = 0;
                        end
                    end
                end
                M_SEARCH: begin
                    cl = m_turn_left ? 2'b01 : 2'b10;
                    cr = m_turn_left ? 2'b10 : 2'b01;
                    if (tr <= 3'd4) begin
                        m_state = M_FOLLOW;
                        m_timer = 0;
                    end else begin
                        m_timer++;
                        if (m_timer >= TIMEOUT) begin
                            m_state = M_HALT;
                            m_timer = 0;
                        end
                    end
                end
                M_OBST: begin
                    if (ob) begin
                        m_timer = 0;
                    end else begin
                        m_timer++;
                        if (m_timer >= CLEAR) begin
                            m_state = M_FOLLOW;
                            m_timer = 0;
                        end
                    end
                end
                default: ;
            endcase
        end
        m_hold_l = cl;
        m_hold_r = cr;
        m_mode   = md;
        drive_wheel(m_left, m_l_until, cl);
        drive_wheel(m_right, m_r_until, cr);
        m_cyc++;
    endtask

    task automatic check_all();
        check($sformatf("left@%0d", m_cyc),  8'(bus.left),      8'(m_left));
        check($sformatf("right@%0d", m_cyc), 8'(bus.right),     8'(m_right));
        check($sformatf("mode@%0d", m_cyc),  8'(bus.mode),      8'(m_mode));
        check($sformatf("fsm@%0d", m_cyc),   8'(bus.fsm_state), 8'(m_state));
    endtask

    // Apply inputs at the falling edge, step the model on the rising edge, sample at the next fall.
    task automatic cycle(input logic st, input logic [2:0] tr, input logic ob);
        bus.start       = st;
        bus.track_state = tr;
        bus.obstacle    = ob;
        @(posedge clk);
        model_step(st, tr, ob);
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_left"},  8'(bus.left),      8'h00);
        check({tag, "_right"}, 8'(bus.right),     8'h00);
        check({tag, "_mode"},  8'(bus.mode),      8'h00);
        check({tag, "_fsm"},   8'(bus.fsm_state), 8'h00);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       st, ob;
        logic [2:0] tr;
        int         kind, len;

        tbl_l = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10};
        tbl_r = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b10};

        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.track_state = 3'd0;
        bus.obstacle    = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_left",  8'(bus.left),      8'h00);
        check("reset_right", 8'(bus.right),     8'h00);
        check("reset_mode",  8'(bus.mode),      8'h00);
        check("reset_fsm",   8'(bus.fsm_state), 8'h00);
        rst = 1'b0;

        // Idle waits for start; outputs follow one clock after entering FOLLOW
        cycle(1'b0, 3'd0, 1'b0);
        cycle(1'b0, 3'd0, 1'b0);
        check("idle_hold_fsm", 8'(bus.fsm_state), 8'd0);
        cycle(1'b1, 3'd0, 1'b0);
        check("start_fsm", 8'(bus.fsm_state), 8'd1);
        cycle(1'b0, 3'd0, 1'b0);
        check("straight_left",  8'(bus.left),  8'h2);
        check("straight_right", 8'(bus.right), 8'h2);

        // Big left: left wheel reverses through two coast cycles
        cycle(1'b0, 3'd2, 1'b0);
        check("rev_dt1_left",  8'(bus.left),  8'h0);
        check("rev_dt1_right", 8'(bus.right), 8'h2);
        cycle(1'b0, 3'd2, 1'b0);
        check("rev_dt2_left", 8'(bus.left), 8'h0);
        cycle(1'b0, 3'd2, 1'b0);
        check("rev_done_left",  8'(bus.left),  8'h1);
        check("rev_done_right", 8'(bus.right), 8'h2);

        // Obstacle stop, clear-time hysteresis with a glitch at clear count 2
        cycle(1'b0, 3'd2, 1'b1);
        check("obst_left",  8'(bus.left),      8'h0);
        check("obst_right", 8'(bus.right),     8'h0);
        check("obst_fsm",   8'(bus.fsm_state), 8'd2);
        for (int i = 0; i < 4; i++) cycle(1'b0, 3'd2, 1'b1);
        cycle(1'b0, 3'd2, 1'b0);
        cycle(1'b0, 3'd2, 1'b0);
        cycle(1'b0, 3'd2, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'd2, 1'b0);
        check("clear3_fsm", 8'(bus.fsm_state), 8'd2);
        cycle(1'b0, 3'd2, 1'b0);
        check("clear4_fsm", 8'(bus.fsm_state), 8'd1);

        // Big right then line lost: SEARCH after three invalid codes, spinning right
        cycle(1'b0, 3'd0, 1'b0);
        cycle(1'b0, 3'd0, 1'b0);
        cycle(1'b0, 3'd1, 1'b0);
        cycle(1'b0, 3'd7, 1'b0);
        cycle(1'b0, 3'd7, 1'b0);
        check("lost2_fsm", 8'(bus.fsm_state), 8'd1);
        cycle(1'b0, 3'd7, 1'b0);
        check("lost3_fsm", 8'(bus.fsm_state), 8'd3);
        cycle(1'b0, 3'd7, 1'b0);
        check("spin_left",  8'(bus.left),  8'h2);
        check("spin_right", 8'(bus.right), 8'h1);
        check("spin_mode",  8'(bus.mode),  8'h0);
        cycle(1'b0, 3'd0, 1'b0);
        check("regain_fsm", 8'(bus.fsm_state), 8'd1);

        // Search timeout to HALT; obstacle ignored there; start resumes
        cycle(1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'd6, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b0, 3'd5, 1'b0);
        check("search9_fsm", 8'(bus.fsm_state), 8'd3);
        cycle(1'b0, 3'd5, 1'b0);
        check("timeout_fsm", 8'(bus.fsm_state), 8'd4);
        cycle(1'b0, 3'd7, 1'b0);
        check("halt_left",  8'(bus.left),  8'h0);
        check("halt_right", 8'(bus.right), 8'h0);
        cycle(1'b0, 3'd0, 1'b1);
        check("halt_obst_fsm", 8'(bus.fsm_state), 8'd4);
        cycle(1'b1, 3'd0, 1'b0);
        check("halt_start_fsm", 8'(bus.fsm_state), 8'd1);

        // Random soak in segments: valid runs, lost-line runs, obstacle bursts, start pulses
        for (int seg = 0; seg < 60; seg++) begin
            kind = int'($urandom_range(0, 9));
            len  = int'($urandom_range(1, 14));
            for (int i = 0; i < len; i++) begin
                st = (kind == 8) && (i == 0);
                ob = (kind == 7) && (i < len / 2);
                if (kind == 5 || kind == 6) tr = 3'($urandom_range(5, 7));
                else                        tr = 3'($urandom_range(0, 4));
                cycle(st, tr, ob);
            end
        end

        // Reset during a dead-time window
        async_reset("rst_pre");
        cycle(1'b1, 3'd0, 1'b0);
        cycle(1'b0, 3'd0, 1'b0);
        cycle(1'b0, 3'd2, 1'b0);
        check("dt_active_left", 8'(bus.left), 8'h0);
        async_reset("rst_dt");
        cycle(1'b0, 3'd0, 1'b0);
        cycle(1'b0, 3'd0, 1'b0);
        check("rst_dt_idle_fsm", 8'(bus.fsm_state), 8'd0);

        // Reset in the middle of an obstacle hold
        cycle(1'b1, 3'd0, 1'b0);
        cycle(1'b0, 3'd0, 1'b1);
        cycle(1'b0, 3'd0, 1'b0);
        check("mid_obst_fsm", 8'(bus.fsm_state), 8'd2);
        async_reset("rst_obst");
        cycle(1'b0, 3'd0, 1'b0);
        check("rst_obst_idle_fsm", 8'(bus.fsm_state), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
